// File: rtl/add_sub_sequencer.sv
// Sequencer for an external combinational adder/subtractor: it latches the operands,
// holds them on the adder for SETTLE cycles, then captures the sum and the flags.
module add_sub_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_mode,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_carry,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             ovf,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam int          MSB      = WIDTH - 1;
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_ready;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;
    logic             r_done;
    logic             w_ovf;

    // Signed overflow of the held operands against the settled adder result.
    // For subtraction the operands must differ in sign for overflow to occur.
    always_comb begin
        w_ovf = 1'b0;
        if (r_mode) begin
            w_ovf = (r_a[MSB] != r_b[MSB]) && (add_sum[MSB] != r_a[MSB]);
        end else begin
            w_ovf = (r_a[MSB] == r_b[MSB]) && (add_sum[MSB] != r_a[MSB]);
        end
    end

    // Control FSM with registered adder operands, result, flags and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_mode  <= sub_in;
                        r_cnt   <= SETTLE_L;
                        r_ready <= 1'b0;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    r_cnt <= r_cnt - 4'd1;
                    // <= also catches a zero count so an illegal SETTLE cannot hang here
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_state <= ST_DRIVE;
                    end
                end
                ST_CAPTURE: begin
                    r_result <= add_sum;
                    r_carry  <= add_carry;
                    r_zero   <= (add_sum == '0);
                    r_ovf    <= w_ovf;
                    r_done   <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign add_a     = r_a;
    assign add_b     = r_b;
    assign add_mode  = r_mode;
    assign result    = r_result;
    assign carry_out = r_carry;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign done      = r_done;

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Bench for add_sub_sequencer: a SETTLE=1 instance with an ideal adder and a SETTLE=4
// instance whose adder only shows the right answer after its inputs have been stable for 3 cycles.
module tb_add_sub_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dsel = 1'b0;
    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic       sub_in = 1'b0;

    logic       start1, ready1, add_mode1, add_carry1, carry1, zero1, ovf1, done1;
    logic [7:0] add_a1, add_b1, add_sum1, res1;
    logic       start2, ready2, add_mode2, add_carry2, carry2, zero2, ovf2, done2;
    logic [7:0] add_a2, add_b2, add_sum2, res2;

    logic       m_ready, m_mode, m_carry, m_zero, m_ovf, m_done;
    logic [7:0] m_a, m_b, m_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign start1 = start & ~dsel;
    assign start2 = start & dsel;

    add_sub_sequencer #(.WIDTH(8), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in), .sub_in(sub_in),
        .ready(ready1), .add_a(add_a1), .add_b(add_b1), .add_mode(add_mode1),
        .add_sum(add_sum1), .add_carry(add_carry1), .result(res1), .carry_out(carry1),
        .zero(zero1), .ovf(ovf1), .done(done1));

    add_sub_sequencer #(.WIDTH(8), .SETTLE(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a_in), .b_in(b_in), .sub_in(sub_in),
        .ready(ready2), .add_a(add_a2), .add_b(add_b2), .add_mode(add_mode2),
        .add_sum(add_sum2), .add_carry(add_carry2), .result(res2), .carry_out(carry2),
        .zero(zero2), .ovf(ovf2), .done(done2));

    // Ideal external adder/subtractor for dut1
    assign {add_carry1, add_sum1} = add_mode1 ? ({1'b0, add_a1} + {1'b0, ~add_b1} + 9'd1)
                                              : ({1'b0, add_a1} + {1'b0, add_b1});

    // Slow adder for dut2: wrong (inverted) output until inputs held 3 cycles
    logic [7:0] pa2, pb2;
    logic       pm2;
    int         stab2 = 0;
    logic [8:0] true2;
    always @(posedge clk) begin
        if (add_a2 !== pa2 || add_b2 !== pb2 || add_mode2 !== pm2) stab2 <= 0;
        else if (stab2 < 10) stab2 <= stab2 + 1;
        pa2 <= add_a2;
        pb2 <= add_b2;
        pm2 <= add_mode2;
    end
    assign true2 = add_mode2 ? ({1'b0, add_a2} + {1'b0, ~add_b2} + 9'd1)
                             : ({1'b0, add_a2} + {1'b0, add_b2});
    assign {add_carry2, add_sum2} = (stab2 >= 3) ? true2 : ~true2;

    assign m_ready = dsel ? ready2 : ready1;
    assign m_a     = dsel ? add_a2 : add_a1;
    assign m_b     = dsel ? add_b2 : add_b1;
    assign m_mode  = dsel ? add_mode2 : add_mode1;
    assign m_res   = dsel ? res2 : res1;
    assign m_carry = dsel ? carry2 : carry1;
    assign m_zero  = dsel ? zero2 : zero1;
    assign m_ovf   = dsel ? ovf2 : ovf1;
    assign m_done  = dsel ? done2 : done1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {carry, zero, ovf, result[7:0]}
    function automatic logic [10:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ua, ub, ur, sa, sb, sr;
        logic c, z, v;
        logic [7:0] r;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        ur = s ? (ua - ub) : (ua + ub);
        sr = s ? (sa - sb) : (sa + sb);
        c  = s ? (ua >= ub) : (ur > 255);
        r  = 8'((ur + 512) % 256);
        z  = (r == 8'd0);
        v  = (sr > 127) || (sr < -128);
        return {c, z, v, r};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        int lat;
        int exp_lat;
        logic got;
        logic [10:0] e;
        exp_lat = dsel ? 5 : 2;
        e = ref_calc(a, b, s);
        @(negedge clk);
        a_in = a; b_in = b; sub_in = s; start = 1'b1;
        check("ready_idle", 32'(m_ready), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; a_in = ~a; b_in = 8'($urandom); sub_in = ~s;
        check("ready_busy", 32'(m_ready), 32'd0);
        check("accept_a", 32'(m_a), 32'(a));
        check("accept_b", 32'(m_b), 32'(b));
        check("accept_mode", 32'(m_mode), 32'(s));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (m_done) got = 1'b1;
            check("hold_ab", {15'd0, m_mode, m_a, m_b}, {15'd0, s, a, b});
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", 32'(m_res), 32'(e[7:0]));
        check("carry", 32'(m_carry), 32'(e[10]));
        check("zero", 32'(m_zero), 32'(e[9]));
        check("ovf", 32'(m_ovf), 32'(e[8]));
        check("ready_done", 32'(m_ready), 32'd1);
        @(posedge clk); #1;
        check("done_pulse", 32'(m_done), 32'd0);
        check("result_hold", 32'(m_res), 32'(e[7:0]));
    endtask

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic       qs[$];
        logic [10:0] e;
        logic seen;

        // Reset state
        #12;
        check("rst_ready", 32'(ready1), 32'd1);
        check("rst_outs", {14'd0, done1, res1, carry1, zero1, ovf1, add_a1}, 32'd0);
        check("rst_ops", {23'd0, add_mode1, add_b1}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_op(8'd15, 8'd11, 1'b1);
        run_op(8'd111, 8'd41, 1'b0);
        check("d_152", 32'(res1), 32'd152);
        check("d_ovf", 32'(ovf1), 32'd1);
        run_op(8'd200, 8'd100, 1'b0);
        check("d_44", {23'd0, carry1, res1}, {23'd0, 1'b1, 8'd44});
        run_op(8'd3, 8'd3, 1'b1);
        check("d_zero", {22'd0, zero1, carry1, res1}, {22'd0, 1'b1, 1'b1, 8'd0});
        run_op(8'd2, 8'd3, 1'b1);
        check("d_borrow", {22'd0, carry1, ovf1, res1}, {22'd0, 1'b0, 1'b0, 8'd255});

        // Random operations
        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // start held high with operands changing every cycle
        for (int ed = 0; ed < 12; ed++) begin
            @(negedge clk);
            a_in = 8'($urandom); b_in = 8'($urandom); sub_in = 1'($urandom_range(0, 1));
            start = 1'b1;
            if (ed % 3 == 0) begin
                qa.push_back(a_in); qb.push_back(b_in); qs.push_back(sub_in);
            end
            @(posedge clk); #1;
            check("bb_done", 32'(done1), (ed % 3 == 2) ? 32'd1 : 32'd0);
            check("bb_ready", 32'(ready1), (ed % 3 == 2) ? 32'd1 : 32'd0);
            if (ed % 3 == 2) begin
                e = ref_calc(qa.pop_front(), qb.pop_front(), qs.pop_front());
                check("bb_result", {20'd0, e[10:8], res1}, {20'd0, carry1, zero1, ovf1, e[7:0]});
            end
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("bb_idle", {30'd0, ready1, done1}, {30'd0, 1'b1, 1'b0});

        // Reset one cycle after accept aborts the operation
        run_op(8'd200, 8'd100, 1'b0);
        @(negedge clk);
        a_in = 8'd9; b_in = 8'd5; sub_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("ar_ready", 32'(ready1), 32'd1);
        check("ar_outs", {14'd0, done1, res1, carry1, zero1, ovf1, add_a1}, 32'd0);
        check("ar_ops", {23'd0, add_mode1, add_b1}, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done1) seen = 1'b1;
        end
        check("ar_no_done", {30'd0, seen, ready1}, {30'd0, 1'b0, 1'b1});
        run_op(8'd9, 8'd5, 1'b0);

        // SETTLE=4 instance with slow adder
        dsel = 1'b1;
        run_op(8'd100, 8'd27, 1'b0);
        run_op(8'd5, 8'd130, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sub_sequencer.md
ADD_SUB_SEQUENCER -- requirements
Module: add_sub_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits.
REQ-002 Parameter SETTLE, default 1, legal 1..15: cycles operands are held on the adder before the result is sampled.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only on a rising edge where ready=1.
REQ-006 a_in  input  WIDTH  operand A, sampled at acceptance.
REQ-007 b_in  input  WIDTH  operand B, sampled at acceptance.
REQ-008 sub_in  input  1  0=A+B, 1=A-B; sampled at acceptance.
REQ-009 ready  output  1  high in IDLE.
REQ-010 add_a, add_b  output  WIDTH each  registered operands to the external combinational adder/subtractor.
REQ-011 add_mode  output  1  registered mode to the adder (1=subtract).
REQ-012 add_sum  input  WIDTH  adder result.
REQ-013 add_carry  input  1  adder carry-out (raw; for subtract, 1 = no borrow).
REQ-014 result  output  WIDTH  captured add_sum.
REQ-015 carry_out  output  1  captured add_carry.
REQ-016 zero  output  1  captured (add_sum == 0).
REQ-017 ovf  output  1  captured two's-complement overflow.
REQ-018 done  output  1  one-cycle pulse when result/flags update.

Function
REQ-019 States SHALL be IDLE, DRIVE, CAPTURE; encoding is free.
REQ-020 IDLE: ready=1; start=1 latches a_in/b_in/sub_in into add_a/add_b/add_mode, loads settle counter with SETTLE, goes to DRIVE.
REQ-021 start while ready=0 SHALL be ignored and not queued.
REQ-022 DRIVE: counter decrements each cycle; at count 1 the next state is CAPTURE; DRIVE lasts exactly SETTLE cycles.
REQ-023 CAPTURE edge: result<=add_sum, carry_out<=add_carry, zero<=(add_sum==0), ovf per REQ-025, done<=1 for one cycle, next state IDLE.
REQ-024 Latency: start accepted at edge 0 -> done=1 and new outputs visible after edge SETTLE+1; ready=1 in the same cycle as done, so back-to-back start is accepted there (throughput one op per SETTLE+2 cycles).
REQ-025 ovf: add: add_a[MSB]==add_b[MSB] and add_sum[MSB]!=add_a[MSB]; sub: add_a[MSB]!=add_b[MSB] and add_sum[MSB]!=add_a[MSB].
REQ-026 add_a/add_b/add_mode SHALL be constant from acceptance through the CAPTURE edge and hold last values in IDLE.
REQ-027 result/carry_out/zero/ovf SHALL hold until the next CAPTURE.
REQ-028 done SHALL be 0 in every cycle other than the one following a CAPTURE edge.
REQ-029 Operand changes on a_in/b_in/sub_in after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, ready=1, done=0, result=0, carry_out=0, zero=0, ovf=0, add_a=0, add_b=0, add_mode=0, counter=0.
REQ-031 rst during DRIVE or CAPTURE SHALL abort the operation with no done pulse; first start is accepted on the first edge with rst=0.

Verification
REQ-032 WIDTH=8, SETTLE=1, sub: A=15, B=11 -> done 2 cycles after accept; result=4, carry_out=1, zero=0, ovf=0.
REQ-033 Add: A=111, B=41 -> result=152, carry_out=0, ovf=1; then add A=200, B=100 -> result=44, carry_out=1, ovf=0.
REQ-034 Sub: A=3, B=3 -> result=0, zero=1, carry_out=1; sub A=2, B=3 -> result=255, carry_out=0, ovf=0.
REQ-035 start held high continuously with changing operands -> exactly one op per 3 cycles, each result matching the operands present at its accept edge; no done between.
REQ-036 SETTLE=4: adder model with 3-cycle-settled output -> correct result, done 5 cycles after accept; add_a/add_b stable throughout.
REQ-037 rst pulsed one cycle after accept -> no done, all outputs 0, ready=1; next start completes normally.
